// File: rtl/frame_buf_seq_pkg.sv
// frame_buf_seq_pkg: shared types, DMA register offsets and buffer address helper
package frame_buf_seq_pkg;

    typedef enum logic [1:0] {IDLE, SRC, DST, KICK} state_t;

    typedef logic [1:0] buf_idx_t;

    localparam logic [3:0] REG_SRC  = 4'd0;
    localparam logic [3:0] REG_DST  = 4'd1;
    localparam logic [3:0] REG_CTRL = 4'd3;

    // Buffer index 0/1/2 maps to offset 0, size, 2*size; a shift avoids a multiplier.
    function automatic logic [31:0] buf_addr(input logic [31:0] base, input logic [31:0] size,
                                             input buf_idx_t i);
        return base + ((i == 2'd0) ? 32'd0 : (i == 2'd1) ? size : (size << 1));
    endfunction

endpackage

// File: rtl/frame_buf_seq_ptr.sv
// frame_buf_seq_ptr: combinational triple-buffer rotation (write first, then read)
import frame_buf_seq_pkg::*;

module frame_buf_seq_ptr (
    input  buf_idx_t w,
    input  buf_idx_t r,
    input  buf_idx_t l,
    input  logic     lv,
    input  logic     wr,
    input  logic     rd,
    output buf_idx_t w_nxt,
    output buf_idx_t r_nxt,
    output buf_idx_t l_nxt,
    output logic     lv_nxt
);

    buf_idx_t l_w;
    logic     lv_w;
    logic     take;

    // A completed write parks its buffer as latest and reclaims the old latest.
    assign w_nxt = wr ? l : w;
    assign l_w   = wr ? w : l;
    assign lv_w  = wr | lv;

    // A read only advances when a fresh frame is waiting; otherwise it repeats.
    assign take   = rd & lv_w;
    assign r_nxt  = take ? l_w : r;
    assign l_nxt  = take ? r : l_w;
    assign lv_nxt = lv_w & ~rd;

endmodule

// File: rtl/frame_buf_seq.sv
// frame_buf_seq: triple-buffer sequencer programming a DMA through register writes.
// Optional statistics counters are enabled by defining FRAME_BUF_SEQ_STATS_EN.
import frame_buf_seq_pkg::*;

module frame_buf_seq #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [31:0] BUF_SIZE  = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        wr_eop,
    input  logic        rd_eop,
    output logic        cfg_write,
    output logic [3:0]  cfg_address,
    output logic [3:0]  cfg_byteenable,
    output logic [31:0] cfg_writedata,
    output logic [1:0]  wr_buf,
    output logic [1:0]  rd_buf,
    output logic        busy
`ifdef FRAME_BUF_SEQ_STATS_EN
    ,
    output logic [15:0] drop_cnt,
    output logic [15:0] rep_cnt
`endif
);

    state_t   state;
    buf_idx_t w, r, l, w_nxt, r_nxt, l_nxt;
    logic     lv, lv_nxt, wp, rp, need_cfg;
    logic     ev_w, ev_r, go;

    // Events seen this cycle count together with those latched earlier.
    assign ev_w = wp | wr_eop;
    assign ev_r = rp | rd_eop;
    assign go   = (state == IDLE) && en && (ev_w || ev_r || need_cfg);

    assign wr_buf = w;
    assign rd_buf = r;

    frame_buf_seq_ptr u_ptr (
        .w      (w),
        .r      (r),
        .l      (l),
        .lv     (lv),
        .wr     (go & ev_w),
        .rd     (go & ev_r),
        .w_nxt  (w_nxt),
        .r_nxt  (r_nxt),
        .l_nxt  (l_nxt),
        .lv_nxt (lv_nxt)
    );

    // Sequencer: rotates pointers on IDLE exit, then writes SRC, DST and CTRL registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            w              <= 2'd0;
            r              <= 2'd1;
            l              <= 2'd2;
            lv             <= 1'b0;
            wp             <= 1'b0;
            rp             <= 1'b0;
            need_cfg       <= 1'b1;
            cfg_write      <= 1'b0;
            cfg_address    <= 4'd0;
            cfg_byteenable <= 4'd0;
            cfg_writedata  <= 32'd0;
            busy           <= 1'b0;
        end else begin
            w  <= w_nxt;
            r  <= r_nxt;
            l  <= l_nxt;
            lv <= lv_nxt;
            wp <= go ? 1'b0 : ev_w;
            rp <= go ? 1'b0 : ev_r;
            case (state)
                IDLE: if (go) begin
                    state          <= SRC;
                    cfg_write      <= 1'b1;
                    cfg_address    <= REG_SRC;
                    cfg_byteenable <= 4'hF;
                    cfg_writedata  <= buf_addr(BASE_ADDR, BUF_SIZE, r_nxt);
                    busy           <= 1'b1;
                end
                SRC: begin
                    state         <= DST;
                    cfg_address   <= REG_DST;
                    cfg_writedata <= buf_addr(BASE_ADDR, BUF_SIZE, w);
                end
                DST: begin
                    state         <= KICK;
                    cfg_address   <= REG_CTRL;
                    cfg_writedata <= 32'h1;
                end
                KICK: begin
                    state          <= IDLE;
                    need_cfg       <= 1'b0;
                    cfg_write      <= 1'b0;
                    cfg_address    <= 4'd0;
                    cfg_byteenable <= 4'd0;
                    cfg_writedata  <= 32'd0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_BUF_SEQ_STATS_EN
    logic drop, rep;

    assign drop = go & ev_w & lv;
    assign rep  = go & ev_r & ~(ev_w | lv);

    // Saturating counts of overwritten unread frames and repeated frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 16'd0;
            rep_cnt  <= 16'd0;
        end else begin
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (rep && rep_cnt != 16'hFFFF) rep_cnt <= rep_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_buf_seq.sv
// tb_frame_buf_seq: directed checks of the frame buffer sequencer
module tb_frame_buf_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wr_eop = 1'b0;
    logic        rd_eop = 1'b0;
    logic        cfg_write;
    logic [3:0]  cfg_address;
    logic [3:0]  cfg_byteenable;
    logic [31:0] cfg_writedata;
    logic [1:0]  wr_buf;
    logic [1:0]  rd_buf;
    logic        busy;
`ifdef FRAME_BUF_SEQ_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] rep_cnt;
`endif

    int n_checks = 0;
    int n_fail = 0;

    frame_buf_seq dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .wr_eop         (wr_eop),
        .rd_eop         (rd_eop),
        .cfg_write      (cfg_write),
        .cfg_address    (cfg_address),
        .cfg_byteenable (cfg_byteenable),
        .cfg_writedata  (cfg_writedata),
        .wr_buf         (wr_buf),
        .rd_buf         (rd_buf),
        .busy           (busy)
`ifdef FRAME_BUF_SEQ_STATS_EN
        ,
        .drop_cnt       (drop_cnt),
        .rep_cnt        (rep_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit settle);
        rst = 1'b1;
        en  = 1'b1;
        tick();
        rst = 1'b0;
        if (settle) repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [42:0] got;
        en  = 1'b0;
        rst = 1'b1;
        tick();
        got = {cfg_write, busy, cfg_address, cfg_byteenable, cfg_writedata, wr_buf, rd_buf};
        n_checks++;
        if (got !== {1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 2'd0, 2'd1}) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", got, {1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 2'd0, 2'd1});
        end
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({cfg_write, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_en_low got=%b want=00", {cfg_write, busy});
        end
    endtask

    task automatic test_init_seq();
        logic [31:0] ed[3];
        logic [3:0]  ea[3];
        ed = '{32'h1002_0000, 32'h1000_0000, 32'h1};
        ea = '{4'd0, 4'd1, 4'd3};
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({cfg_write, busy, cfg_byteenable, cfg_address, cfg_writedata} !== {2'b11, 4'hF, ea[i], ed[i]}) begin
                n_fail++;
                $display("FAIL init_seq[%0d] got=%h/%h/%h want=%h/%h", i, cfg_write, cfg_address, cfg_writedata, ea[i], ed[i]);
            end
        end
        tick();
        n_checks++;
        if ({cfg_write, busy, cfg_byteenable} !== 6'd0) begin
            n_fail++;
            $display("FAIL init_done got=%b want=0", {cfg_write, busy, cfg_byteenable});
        end
    endtask

    task automatic test_write_eop();
        logic [31:0] ed[3];
        logic [3:0]  ea[3];
        ed = '{32'h1002_0000, 32'h1004_0000, 32'h1};
        ea = '{4'd0, 4'd1, 4'd3};
        wr_eop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            wr_eop = 1'b0;
            n_checks++;
            if ({cfg_write, busy, cfg_byteenable, cfg_address, cfg_writedata} !== {2'b11, 4'hF, ea[i], ed[i]}) begin
                n_fail++;
                $display("FAIL wr_seq[%0d] got=%h/%h want=%h/%h", i, cfg_address, cfg_writedata, ea[i], ed[i]);
            end
        end
        tick();
        n_checks++;
        if ({wr_buf, rd_buf} !== {2'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL wr_ptrs got=%0d/%0d want=2/1", wr_buf, rd_buf);
        end
    endtask

    task automatic test_read_eop();
        logic [31:0] ed[3];
        logic [3:0]  ea[3];
        ed = '{32'h1000_0000, 32'h1004_0000, 32'h1};
        ea = '{4'd0, 4'd1, 4'd3};
        rd_eop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            rd_eop = 1'b0;
            n_checks++;
            if ({cfg_write, busy, cfg_byteenable, cfg_address, cfg_writedata} !== {2'b11, 4'hF, ea[i], ed[i]}) begin
                n_fail++;
                $display("FAIL rd_seq[%0d] got=%h/%h want=%h/%h", i, cfg_address, cfg_writedata, ea[i], ed[i]);
            end
        end
        tick();
        n_checks++;
        if ({wr_buf, rd_buf} !== {2'd2, 2'd0}) begin
            n_fail++;
            $display("FAIL rd_ptrs got=%0d/%0d want=2/0", wr_buf, rd_buf);
        end
    endtask

    task automatic test_repeat();
        do_reset(1'b1);
        rd_eop = 1'b1;
        tick();
        rd_eop = 1'b0;
        n_checks++;
        if ({cfg_write, cfg_address, cfg_writedata} !== {1'b1, 4'd0, 32'h1002_0000}) begin
            n_fail++;
            $display("FAIL repeat_src got=%h/%h want=0/10020000", cfg_address, cfg_writedata);
        end
        tick();
        n_checks++;
        if ({cfg_address, cfg_writedata, rd_buf} !== {4'd1, 32'h1000_0000, 2'd1}) begin
            n_fail++;
            $display("FAIL repeat_dst got=%h/%h rd=%0d want=1/10000000 rd=1", cfg_address, cfg_writedata, rd_buf);
        end
`ifdef FRAME_BUF_SEQ_STATS_EN
        n_checks++;
        if (rep_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL repeat_cnt got rep=%0d drop=%0d want rep=1 drop=0", rep_cnt, drop_cnt);
        end
`endif
        tick();
        tick();
    endtask

    task automatic test_drop();
        do_reset(1'b1);
        wr_eop = 1'b1;
        tick();
        wr_eop = 1'b0;
        repeat (3) tick();
        wr_eop = 1'b1;
        tick();
        wr_eop = 1'b0;
        n_checks++;
        if ({cfg_address, cfg_writedata} !== {4'd0, 32'h1002_0000}) begin
            n_fail++;
            $display("FAIL drop_src got=%h/%h want=0/10020000", cfg_address, cfg_writedata);
        end
        tick();
        n_checks++;
        if ({cfg_address, cfg_writedata, wr_buf, rd_buf} !== {4'd1, 32'h1000_0000, 2'd0, 2'd1}) begin
            n_fail++;
            $display("FAIL drop_dst got=%h/%h w=%0d r=%0d want=1/10000000 w=0 r=1", cfg_address, cfg_writedata, wr_buf, rd_buf);
        end
`ifdef FRAME_BUF_SEQ_STATS_EN
        n_checks++;
        if (drop_cnt !== 16'd1 || rep_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL drop_cnt got drop=%0d rep=%0d want drop=1 rep=0", drop_cnt, rep_cnt);
        end
`endif
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        tick();
        tick();
        wr_eop = 1'b1;
        rd_eop = 1'b1;
        tick();
        wr_eop = 1'b0;
        rd_eop = 1'b0;
        n_checks++;
        if ({cfg_address, cfg_writedata, wr_buf, rd_buf} !== {4'd3, 32'h1, 2'd0, 2'd1}) begin
            n_fail++;
            $display("FAIL b2b_kick got=%h/%h w=%0d r=%0d want=3/1 w=0 r=1", cfg_address, cfg_writedata, wr_buf, rd_buf);
        end
        tick();
        n_checks++;
        if (cfg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle got=%b want=0", cfg_write);
        end
        tick();
        n_checks++;
        if ({cfg_write, cfg_address, cfg_writedata, rd_buf} !== {1'b1, 4'd0, 32'h1000_0000, 2'd0}) begin
            n_fail++;
            $display("FAIL b2b_src got=%h/%h r=%0d want=0/10000000 r=0", cfg_address, cfg_writedata, rd_buf);
        end
        tick();
        n_checks++;
        if ({cfg_address, cfg_writedata, wr_buf} !== {4'd1, 32'h1004_0000, 2'd2}) begin
            n_fail++;
            $display("FAIL b2b_dst got=%h/%h w=%0d want=1/10040000 w=2", cfg_address, cfg_writedata, wr_buf);
        end
        repeat (4) tick();
        n_checks++;
        if ({cfg_write, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_single got=%b want=00", {cfg_write, busy});
        end
    endtask

    task automatic test_abort();
        do_reset(1'b1);
        wr_eop = 1'b1;
        tick();
        wr_eop = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cfg_write, busy, wr_buf, rd_buf} !== {2'b00, 2'd0, 2'd1}) begin
            n_fail++;
            $display("FAIL abort got=%b w=%0d r=%0d want=00 w=0 r=1", {cfg_write, busy}, wr_buf, rd_buf);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({cfg_write, cfg_address, cfg_writedata} !== {1'b1, 4'd0, 32'h1002_0000}) begin
            n_fail++;
            $display("FAIL abort_reprog got=%b/%h/%h want=1/0/10020000", cfg_write, cfg_address, cfg_writedata);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_init_seq();
        test_write_eop();
        test_read_eop();
        test_repeat();
        test_drop();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buf_seq.md
FRAME_BUF_SEQ -- requirements
Module: frame_buf_seq

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning byte address of buffer 0.
REQ-002 SHALL have parameter BUF_SIZE, default 32'h0002_0000, meaning address stride between buffers.
REQ-003 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: en  in  1  sequencing enable; wr_eop  in  1  write-side frame complete (one-cycle pulse); rd_eop  in  1  read-side frame complete (one-cycle pulse).
REQ-005 SHALL have ports: cfg_write  out  1; cfg_address  out  4; cfg_byteenable  out  4; cfg_writedata  out  32. Together these form the DMA register-write master; the slave has no waitrequest.
REQ-006 SHALL have ports: wr_buf  out  2  current write buffer index; rd_buf  out  2  current read buffer index; busy  out  1  programming in progress.

Function
REQ-007 SHALL keep three buffer indices W, R, L (all distinct, each 0..2) plus flag lv (L holds an unread complete frame).
REQ-008 SHALL, on a write completion, set L<=W, W<=old L, lv<=1.
REQ-009 SHALL, on a read completion with lv=1, set R<=L, L<=old R, lv<=0; with lv=0, leave R unchanged (repeat frame).
REQ-010 SHALL, when both completions occur in the same cycle, apply the write update first, then the read update on the result (read takes the newly completed frame).
REQ-011 SHALL latch wr_eop/rd_eop into pending flags; pending flags are consumed only in state IDLE, so events arriving during programming are never lost.
REQ-012 SHALL implement FSM states IDLE -> SRC -> DST -> KICK -> IDLE, one cycle per state.
REQ-013 SHALL leave IDLE when en=1 and (pending event or need_cfg=1), updating pointers in that same cycle.
REQ-014 SHALL in SRC drive cfg_write=1, cfg_address=0, cfg_writedata=BASE_ADDR+R*BUF_SIZE.
REQ-015 SHALL in DST drive cfg_write=1, cfg_address=1, cfg_writedata=BASE_ADDR+W*BUF_SIZE.
REQ-016 SHALL in KICK drive cfg_write=1, cfg_address=3, cfg_writedata=32'h1, then clear need_cfg.
REQ-017 SHALL drive cfg_byteenable=4'hF whenever cfg_write=1, cfg outputs 0 in IDLE, and busy=1 in SRC/DST/KICK.
REQ-018 SHALL compute addresses in 32-bit modulo arithmetic without a multiplier (index 0/1/2 selects 0, BUF_SIZE, 2*BUF_SIZE).
REQ-019 SHALL complete a running programming sequence even when en falls mid-sequence; en gates only IDLE exit.
REQ-020 SHALL drive wr_buf=W and rd_buf=R combinationally from registers.

Reset
REQ-021 SHALL on rst set W=0, R=1, L=2, lv=0, pending flags 0, state IDLE, need_cfg=1, all cfg outputs 0, busy 0.
REQ-022 SHALL, when rst is asserted mid-sequence, abort immediately; the DMA is reprogrammed from scratch once en=1.

Configuration
REQ-023 SHALL, with macro FRAME_BUF_SEQ_STATS_EN defined, add outputs drop_cnt and rep_cnt (16 bits each, saturating, reset 0).
REQ-024 SHALL increment drop_cnt on a write completion with lv already 1, and rep_cnt on a read completion with lv=0.
REQ-025 SHALL, without the macro, omit the drop_cnt and rep_cnt ports and logic entirely, leaving behaviour otherwise identical.

Structure
REQ-026 SHALL place the state enum, 2-bit buffer index typedef and register offsets (SRC=0, DST=1, CTRL=3) in shared package frame_buf_seq_pkg.
REQ-027 SHALL isolate the pointer rotation of REQ-008..REQ-010 in sub-module frame_buf_seq_ptr (combinational next-W/R/L/lv).

Verification
REQ-028 SHALL cover: release rst with en=1 -> 3 writes in cycles 1-3: (0, 32'h1002_0000), (1, 32'h1000_0000), (3, 32'h1).
REQ-029 SHALL cover: wr_eop pulse -> W=2, L=0, lv=1; next sequence writes DST=32'h1004_0000.
REQ-030 SHALL cover: wr_eop followed later by rd_eop -> R=0, lv=0; SRC=32'h1000_0000.
REQ-031 SHALL cover: rd_eop with lv=0 -> R remains 1, SRC=32'h1002_0000 (frame repeat), rep_cnt=1 with macro defined.
REQ-032 SHALL cover: two wr_eop pulses without rd_eop -> second sets drop_cnt=1, R stays 1, W/L distinct from 1.
REQ-033 SHALL cover: wr_eop and rd_eop in the same cycle during DST -> both latched; after KICK, one new sequence with R=old W.
